// File: rtl/adc_fifo_pkg.sv
// Shared constants and width helpers for the ADC result FIFO slice.
// Optional feature macro used by this slice: ADC_FIFO_IRQ_EN.
package adc_fifo_pkg;

  localparam int unsigned DEPTH_DEF = 8;
  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned LEVEL_W   = $clog2(DEPTH_DEF) + 1;
  localparam int unsigned PTR_W     = $clog2(DEPTH_DEF);

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/adc_result_fifo_if.sv
// Result push stream and FWFT valid/ready read stream of the ADC result FIFO.
// master = oversampler + reader side, slave = FIFO.
interface adc_result_fifo_if
  import adc_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
);
  logic [WIDTH-1:0] result_in;
  logic             result_strobe_in;
  logic [WIDTH-1:0] rd_data_out;
  logic             rd_valid_out;
  logic             rd_ready_in;

  modport master (
    output result_in, result_strobe_in, rd_ready_in,
    input  rd_data_out, rd_valid_out
  );

  modport slave (
    input  result_in, result_strobe_in, rd_ready_in,
    output rd_data_out, rd_valid_out
  );
endinterface

// File: rtl/adc_fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
module adc_fifo_mem
  import adc_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned AW    = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/adc_result_fifo.sv
// First-word-fall-through FIFO for oversampled ADC results with sticky overflow.
// ADC_FIFO_IRQ_EN adds threshold_in / irq_out (level threshold or overflow interrupt).
module adc_result_fifo
  import adc_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  adc_result_fifo_if.slave              fifo_if,
  input  logic                          flush_in,
  output logic [level_width(DEPTH)-1:0] level_out,
  output logic                          overflow_out,
  input  logic                          overflow_clr_in
`ifdef ADC_FIFO_IRQ_EN
  ,
  input  logic [level_width(DEPTH)-1:0] threshold_in,
  output logic                          irq_out
`endif
);
  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned LW = level_width(DEPTH);

  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    level, level_nxt;
  logic             valid;
  logic             ovf, ovf_nxt;
  logic             full, push, pop, drop;
  logic [WIDTH-1:0] head;

  // Flush masks both push and pop; a push into a full FIFO is legal only with a pop.
  always_comb begin
    full      = (level == LW'(DEPTH));
    pop       = valid & fifo_if.rd_ready_in & ~flush_in;
    push      = fifo_if.result_strobe_in & (~full | pop) & ~flush_in;
    drop      = fifo_if.result_strobe_in & full & ~pop & ~flush_in;
    level_nxt = level;
    if (flush_in)        level_nxt = '0;
    else if (push & ~pop) level_nxt = level + LW'(1);
    else if (pop & ~push) level_nxt = level - LW'(1);
    ovf_nxt = ovf;
    if (drop)                 ovf_nxt = 1'b1;
    else if (overflow_clr_in) ovf_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      valid  <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (flush_in) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
      level <= level_nxt;
      valid <= (level_nxt != '0);
      ovf   <= ovf_nxt;
    end
  end

`ifdef ADC_FIFO_IRQ_EN
  // Registered from next-state values so irq_out lines up with level_out/overflow_out.
  always_ff @(posedge clk) begin
    if (rst) irq_out <= 1'b0;
    else     irq_out <= ((threshold_in != '0) && (level_nxt >= threshold_in)) || ovf_nxt;
  end
`endif

  adc_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (push & ~rst),
    .waddr (wr_ptr),
    .wdata (fifo_if.result_in),
    .raddr (rd_ptr),
    .rdata (head)
  );

  assign fifo_if.rd_data_out  = valid ? head : '0;
  assign fifo_if.rd_valid_out = valid;
  assign level_out            = level;
  assign overflow_out         = ovf;
endmodule
